// File: rtl/umem_arbiter.sv
// Single-port unified memory arbiter: data-priority grants with bounded
// fetch starvation, one-cycle read response and fetch statistics.
module umem_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int MEM_AW     = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr_count,
    output logic [31:0]       fetch_stall_count
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;

    logic [SW-1:0] streak;
    logic [1:0]    owner;
    logic          err_q;
    logic          if_mis;
    logic          dm_mis;
    logic          streak_full;

    assign if_mis      = |if_addr[1:0];
    assign dm_mis      = |dm_addr[1:0];
    assign streak_full = (streak == SW'(MAX_STREAK));

    assign dm_gnt = !reset & dm_req & !(if_req & streak_full);
    assign if_gnt = !reset & if_req & !dm_gnt;

    // Misaligned requests are accepted but never touch the array.
    assign mem_en    = (dm_gnt & !dm_mis) | (if_gnt & !if_mis);
    assign mem_we    = dm_gnt & !dm_mis & dm_we;
    assign mem_addr  = dm_gnt ? dm_addr[MEM_AW+1:2] : if_addr[MEM_AW+1:2];
    assign mem_wdata = dm_wdata;

    // Reset squashes a response already in flight.
    assign if_rvalid = !reset & (owner == OWN_IF);
    assign dm_rvalid = !reset & (owner == OWN_DM);
    assign if_err    = if_rvalid & err_q;
    assign dm_err    = dm_rvalid & err_q;
    assign if_rdata  = (if_rvalid & !err_q) ? mem_rdata : 32'd0;
    assign dm_rdata  = (dm_rvalid & !err_q) ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak            <= '0;
            owner             <= OWN_NONE;
            err_q             <= 1'b0;
            instr_count       <= 32'd0;
            fetch_stall_count <= 32'd0;
        end else begin
            if (dm_gnt & if_req)
                streak <= streak + 1'b1;
            else
                streak <= '0;

            unique case (1'b1)
                if_gnt: begin
                    owner <= OWN_IF;
                    err_q <= if_mis;
                end
                dm_gnt & (!dm_we | dm_mis): begin
                    owner <= OWN_DM;
                    err_q <= dm_mis;
                end
                default: begin
                    owner <= OWN_NONE;
                    err_q <= 1'b0;
                end
            endcase

            instr_count <= instr_count + {31'd0, if_rvalid};
            fetch_stall_count <= fetch_stall_count
                               + {31'd0, if_req & !if_gnt};
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// Scoreboard bench for umem_arbiter: expected responses are queued at
// grant time and matched against rvalid/rdata/err one cycle later.
module tb_umem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt, dm_rvalid, dm_err;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] instr_count, fetch_stall_count;

    logic [31:0] ram    [0:1023];
    logic [31:0] shadow [0:1023];
    logic [32:0] ifq[$];
    logic [32:0] dmq[$];
    int checks = 0;
    int errors = 0;

    umem_arbiter #(.MAX_STREAK(4), .MEM_AW(30)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .instr_count(instr_count), .fetch_stall_count(fetch_stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = 32'h9E3779B1 * i + 32'h1234;
            shadow[i] = 32'h9E3779B1 * i + 32'h1234;
        end
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic clk_step();
        logic [32:0] e;
        @(posedge clk); #1;
        checks++;
        if (if_rvalid !== (ifq.size() != 0)) begin
            errors++;
            $display("FAIL if_rvalid got %b exp %0d", if_rvalid, ifq.size());
        end
        if (ifq.size() != 0) begin
            e = ifq.pop_front();
            if (if_rvalid === 1'b1) begin
                checks++;
                if ({if_err, if_rdata} !== e) begin
                    errors++;
                    $display("FAIL if_resp got %b/%h exp %b/%h",
                             if_err, if_rdata, e[32], e[31:0]);
                end
            end
        end
        checks++;
        if (dm_rvalid !== (dmq.size() != 0)) begin
            errors++;
            $display("FAIL dm_rvalid got %b exp %0d", dm_rvalid, dmq.size());
        end
        if (dmq.size() != 0) begin
            e = dmq.pop_front();
            if (dm_rvalid === 1'b1) begin
                checks++;
                if ({dm_err, dm_rdata} !== e) begin
                    errors++;
                    $display("FAIL dm_resp got %b/%h exp %b/%h",
                             dm_err, dm_rdata, e[32], e[31:0]);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ifq.delete(); dmq.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1;
        if_addr = 32'h0040_0000; dm_addr = 32'h0040_0080;
        @(posedge clk); #1;
        checks++;
        if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_gnt got %b exp 000", {if_gnt, dm_gnt, mem_en});
        end
        checks++;
        if ({if_rvalid, dm_rvalid, if_err, dm_err} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_valid got %b exp 0000",
                     {if_rvalid, dm_rvalid, if_err, dm_err});
        end
        checks++;
        if ({instr_count, fetch_stall_count} !== 64'd0) begin
            errors++;
            $display("FAIL rst_cnt got %0d/%0d exp 0/0",
                     instr_count, fetch_stall_count);
        end
        do_reset();
    endtask

    task automatic test_fetch_stream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; if_addr = 32'h0040_0000 + 32'(4 * i);
            #1;
            checks++;
            if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010) begin
                errors++;
                $display("FAIL fs_gnt[%0d] got %b exp 1010", i,
                         {if_gnt, dm_gnt, mem_en, mem_we});
            end
            checks++;
            if (mem_addr !== 30'h0010_0000 + 30'(i)) begin
                errors++;
                $display("FAIL fs_addr[%0d] got %h exp %h", i,
                         mem_addr, 30'h0010_0000 + 30'(i));
            end
            ifq.push_back({1'b0, shadow[i]});
            clk_step();
        end
        if_req = 1'b0;
        clk_step();
        checks++;
        if ({instr_count, fetch_stall_count} !== {32'd3, 32'd0}) begin
            errors++;
            $display("FAIL fs_cnt got %0d/%0d exp 3/0",
                     instr_count, fetch_stall_count);
        end
    endtask

    task automatic test_contention();
        logic [9:0] pat;
        pat = 10'b10_0001_0000;
        do_reset();
        if_addr = 32'h0040_0000; dm_addr = 32'h0040_0080; dm_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if_req = 1'b1; dm_req = 1'b1;
            #1;
            checks++;
            if ({if_gnt, dm_gnt} !== {pat[i], !pat[i]}) begin
                errors++;
                $display("FAIL ct_gnt[%0d] got %b exp %b", i,
                         {if_gnt, dm_gnt}, {pat[i], !pat[i]});
            end
            checks++;
            if (mem_addr !== (pat[i] ? 30'h0010_0000 : 30'h0010_0020)) begin
                errors++;
                $display("FAIL ct_addr[%0d] got %h", i, mem_addr);
            end
            if (pat[i]) ifq.push_back({1'b0, shadow[0]});
            else        dmq.push_back({1'b0, shadow[32]});
            clk_step();
        end
        if_req = 1'b0; dm_req = 1'b0;
        clk_step();
        checks++;
        if ({instr_count, fetch_stall_count} !== {32'd2, 32'd8}) begin
            errors++;
            $display("FAIL ct_cnt got %0d/%0d exp 2/8",
                     instr_count, fetch_stall_count);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h0040_0040; dm_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
            {3'b111, 30'h0010_0010, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sl_store got %b%b%b %h %h",
                     dm_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        shadow[16] = 32'hDEAD_BEEF;
        clk_step();
        dm_we = 1'b0;
        #1;
        checks++;
        if ({dm_gnt, mem_en, mem_we} !== 3'b110) begin
            errors++;
            $display("FAIL sl_load got %b exp 110", {dm_gnt, mem_en, mem_we});
        end
        dmq.push_back({1'b0, shadow[16]});
        clk_step();
        dm_req = 1'b0;
    endtask

    task automatic test_misaligned();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0040_0041;
        #1;
        checks++;
        if ({dm_gnt, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL ma_ld got %b exp 10", {dm_gnt, mem_en});
        end
        dmq.push_back({1'b1, 32'd0});
        clk_step();
        dm_we = 1'b1; dm_addr = 32'h0040_0043; dm_wdata = 32'h1234_5678;
        #1;
        checks++;
        if ({dm_gnt, mem_en, mem_we} !== 3'b100) begin
            errors++;
            $display("FAIL ma_st got %b exp 100", {dm_gnt, mem_en, mem_we});
        end
        dmq.push_back({1'b1, 32'd0});
        clk_step();
        dm_req = 1'b0; dm_we = 1'b0;
        if_req = 1'b1; if_addr = 32'h0040_0002;
        #1;
        checks++;
        if ({if_gnt, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL ma_if got %b exp 10", {if_gnt, mem_en});
        end
        ifq.push_back({1'b1, 32'd0});
        clk_step();
        if_req = 1'b0;
        dm_req = 1'b1; dm_addr = 32'h0040_0040;
        dmq.push_back({1'b0, shadow[16]});
        clk_step();
        dm_req = 1'b0;
        clk_step();
        checks++;
        if (instr_count !== 32'd1) begin
            errors++;
            $display("FAIL ma_cnt got %0d exp 1", instr_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        if_addr = 32'h0040_0000; dm_addr = 32'h0040_0080;
        dmq.push_back({1'b0, shadow[32]});
        clk_step();
        dm_req = 1'b0;
        ifq.push_back({1'b0, shadow[0]});
        clk_step();
        if_addr = 32'h0040_0004;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_gnt got %b exp 1", if_gnt);
        end
        @(posedge clk);
        reset = 1'b1; if_req = 1'b0;
        #1;
        checks++;
        if ({if_rvalid, if_err, if_rdata} !== 34'd0) begin
            errors++;
            $display("FAIL rm_drop got %b %h exp 0", if_rvalid, if_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({instr_count, fetch_stall_count, if_rvalid} !== 65'd0) begin
            errors++;
            $display("FAIL rm_cnt got %0d/%0d/%b exp 0/0/0",
                     instr_count, fetch_stall_count, if_rvalid);
        end
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h0040_0008;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rm_first got %b exp 1", if_gnt);
        end
        ifq.push_back({1'b0, shadow[2]});
        clk_step();
        if_req = 1'b0;
        clk_step();
    endtask

    task automatic test_streak_clear();
        do_reset();
        if_addr = 32'h0040_0000; dm_addr = 32'h0040_0080; dm_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_req = (i != 3); dm_req = 1'b1;
            #1;
            checks++;
            if ({if_gnt, dm_gnt} !== 2'b01) begin
                errors++;
                $display("FAIL sc_pre[%0d] got %b exp 01", i, {if_gnt, dm_gnt});
            end
            dmq.push_back({1'b0, shadow[32]});
            clk_step();
        end
        for (int i = 0; i < 8; i++) begin
            if_req = 1'b1; dm_req = 1'b1;
            #1;
            checks++;
            if (if_gnt !== (i == 4)) begin
                errors++;
                $display("FAIL sc_run[%0d] got %b exp %b", i, if_gnt, i == 4);
            end
            if (i == 4) ifq.push_back({1'b0, shadow[0]});
            else        dmq.push_back({1'b0, shadow[32]});
            clk_step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
            errors++;
            $display("FAIL sc_rst got %b exp 000", {if_gnt, dm_gnt, mem_en});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (if_gnt !== (i == 4)) begin
                errors++;
                $display("FAIL sc_post[%0d] got %b exp %b", i, if_gnt, i == 4);
            end
            if (i == 4) ifq.push_back({1'b0, shadow[0]});
            else        dmq.push_back({1'b0, shadow[32]});
            clk_step();
        end
        if_req = 1'b0; dm_req = 1'b0;
        clk_step();
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch_stream();
        test_contention();
        test_store_load();
        test_misaligned();
        test_reset_mid();
        test_streak_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
